// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the Mini SRC datapath:
// IR/CON_FF flow up from the datapath, register strobes flow down.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        run;
  logic [4:0]  op_sel;
  logic PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, C_out, In_out, R_out, BAout;
  logic MAR_rd, MDR_rd, IR_rd, PC_rd, Y_rd, Zlo_rd, CON_rd, Rin;
  logic Gra, Grb, Grc;
  logic IncPC, Read, Write;

  modport master (
    input  IR, CON_FF,
    output run, op_sel,
    output PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, C_out, In_out, R_out, BAout,
    output MAR_rd, MDR_rd, IR_rd, PC_rd, Y_rd, Zlo_rd, CON_rd, Rin,
    output Gra, Grb, Grc, IncPC, Read, Write
  );

  modport slave (
    output IR, CON_FF,
    input  run, op_sel,
    input  PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, C_out, In_out, R_out, BAout,
    input  MAR_rd, MDR_rd, IR_rd, PC_rd, Y_rd, Zlo_rd, CON_rd, Rin,
    input  Gra, Grb, Grc, IncPC, Read, Write
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch T0-T2, per-opcode
// execute T3-T7, halt until clr. Strobes decode combinationally from state + IR.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter int         STEP_W  = 3
) (
  input logic               clk,
  input logic               clr,
  control_sequencer_if.master bus
);
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2;
  localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14;
  localparam logic [4:0] OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19, OP_JR = 5'd20;
  localparam logic [4:0] OP_IN = 5'd22, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   last;
  logic [4:0]          opc;
  logic                is_rr;

  assign opc   = bus.IR[31:27];
  assign is_rr = (opc >= 5'd3) && (opc <= 5'd11);

  // Final step of each instruction; codes with no execute phase end at T2.
  always_comb begin
    last = STEP_W'(2);
    if (is_rr) last = STEP_W'(5);
    else begin
      case (opc)
        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:   last = STEP_W'(5);
        OP_NEG, OP_NOT:                     last = STEP_W'(4);
        OP_LD, OP_ST:                       last = STEP_W'(7);
        OP_BR:                              last = STEP_W'(6);
        OP_JR, OP_IN, OP_MFHI, OP_MFLO:     last = STEP_W'(3);
        default:                            last = STEP_W'(2);
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          step  <= '0;
        end
        RUN: begin
          if (step == STEP_W'(2) && opc == OP_HALT) begin
            state <= HALT;
            step  <= '0;
          end else if (step == last) step <= '0;
          else                       step <= step + 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

  always_comb begin
    bus.run = 1'b0; bus.op_sel = 5'd0;
    bus.PC_out = 1'b0; bus.MDR_out = 1'b0; bus.Zlo_out = 1'b0; bus.Zhi_out = 1'b0;
    bus.HI_out = 1'b0; bus.LO_out = 1'b0; bus.C_out = 1'b0; bus.In_out = 1'b0;
    bus.R_out = 1'b0; bus.BAout = 1'b0;
    bus.MAR_rd = 1'b0; bus.MDR_rd = 1'b0; bus.IR_rd = 1'b0; bus.PC_rd = 1'b0;
    bus.Y_rd = 1'b0; bus.Zlo_rd = 1'b0; bus.CON_rd = 1'b0; bus.Rin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
    if (state == RUN) begin
      bus.run = 1'b1;
      case (step)
        STEP_W'(0): begin bus.PC_out = 1'b1; bus.MAR_rd = 1'b1; bus.IncPC = 1'b1; bus.Zlo_rd = 1'b1; end
        STEP_W'(1): begin bus.Zlo_out = 1'b1; bus.PC_rd = 1'b1; bus.Read = 1'b1; bus.MDR_rd = 1'b1; end
        STEP_W'(2): begin bus.MDR_out = 1'b1; bus.IR_rd = 1'b1; end
        STEP_W'(3): begin
          if (is_rr) begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_rd = 1'b1; end
          else case (opc)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST:
              begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.BAout = 1'b1; bus.Y_rd = 1'b1; end
            OP_NEG, OP_NOT:
              begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Zlo_rd = 1'b1; bus.op_sel = opc; end
            OP_BR:   begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.CON_rd = 1'b1; end
            OP_JR:   begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_rd = 1'b1; end
            OP_IN:   begin bus.In_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_MFHI: begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_MFLO: begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            default: ;
          endcase
        end
        STEP_W'(4): begin
          if (is_rr) begin bus.Grc = 1'b1; bus.R_out = 1'b1; bus.Zlo_rd = 1'b1; bus.op_sel = opc; end
          else case (opc)
            OP_ADDI, OP_LDI, OP_LD, OP_ST:
                     begin bus.C_out = 1'b1; bus.Zlo_rd = 1'b1; bus.op_sel = ALU_ADD; end
            OP_ANDI: begin bus.C_out = 1'b1; bus.Zlo_rd = 1'b1; bus.op_sel = 5'b00101; end
            OP_ORI:  begin bus.C_out = 1'b1; bus.Zlo_rd = 1'b1; bus.op_sel = 5'b00110; end
            OP_NEG, OP_NOT: begin bus.Zlo_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_BR:   begin bus.PC_out = 1'b1; bus.Y_rd = 1'b1; end
            default: ;
          endcase
        end
        STEP_W'(5): begin
          if (is_rr) begin bus.Zlo_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          else case (opc)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                          begin bus.Zlo_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_LD, OP_ST: begin bus.Zlo_out = 1'b1; bus.MAR_rd = 1'b1; end
            OP_BR:        begin bus.C_out = 1'b1; bus.Zlo_rd = 1'b1; bus.op_sel = ALU_ADD; end
            default: ;
          endcase
        end
        STEP_W'(6): begin
          case (opc)
            OP_LD: begin bus.Read = 1'b1; bus.MDR_rd = 1'b1; end
            OP_ST: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.MDR_rd = 1'b1; end
            // Branch taken only when the condition flop is set during this step.
            OP_BR: begin bus.Zlo_out = 1'b1; bus.PC_rd = bus.CON_FF; end
            default: ;
          endcase
        end
        STEP_W'(7): begin
          case (opc)
            OP_LD: begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_ST: bus.Write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule
